// File: rtl/illusion_pkg.sv
// Shared definitions for the primitive pipeline: entry width and queue states.
package illusion_pkg;

  // Bit width of one processed primitive (TriangleData).
  localparam int TRIANGLE_DATA_W = 96;

  // Storage occupancy states of the primitive queue.
  typedef enum logic [1:0] {
    Q_EMPTY     = 2'd0,  // nothing held
    Q_FILLING   = 2'd1,  // entries in RAM, output register not yet loaded
    Q_STREAMING = 2'd2,  // output register valid, room left
    Q_FULL      = 2'd3   // DEPTH entries held
  } queue_state_e;

endpackage

// File: rtl/RAM_1R_1W.sv
// Simple dual-port entry storage: one write port, one registered read port.
module RAM_1R_1W #(
  parameter int DEPTH = 32,
  parameter int SIZE  = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [SIZE-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [SIZE-1:0] rd_data
);

  logic [SIZE-1:0] mem [DEPTH];
  logic [SIZE-1:0] rd_data_q;

  // Write and synchronous read; read data holds when rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/primitive_queue.sv
// Primitive FIFO with registered head. The RAM read register doubles as the
// output register: a read is only issued when the head is empty or being
// popped, so the head data stays put while the consumer stalls.
module primitive_queue
  import illusion_pkg::*;
#(
  parameter int WIDTH       = TRIANGLE_DATA_W,
  parameter int DEPTH       = 32,
  parameter int ALMOST_FULL = DEPTH - 4
) (
  input  logic                   aClock,
  input  logic                   aReset,
  input  logic                   aPushValid,
  input  logic [WIDTH-1:0]       aPushData,
  output logic                   anOutPushReady,
  output logic                   anOutPopValid,
  output logic [WIDTH-1:0]       anOutPopData,
  input  logic                   aPopReady,
  input  logic                   aFlush,
  output logic [$clog2(DEPTH):0] anOutCount,
  output logic                   anOutAlmostFull,
  output logic                   anOutOverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL);

  // Pointers carry one extra bit so full and empty RAM are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  queue_state_e  state_q, state_d;

  logic push, pop, ram_rd, ram_nonempty;

  // Ready depends on registered state only (FULL <=> count == DEPTH).
  assign anOutPushReady  = (state_q != Q_FULL);
  assign anOutPopValid   = out_valid_q;
  assign anOutCount      = count_q;
  assign anOutAlmostFull = (count_q >= AF_CNT);
  assign anOutOverflow   = overflow_q;

  // Next-state: handshakes, prefetch, pointer/count update, flush, state.
  always_comb begin
    push         = aPushValid & anOutPushReady & ~aFlush;
    pop          = out_valid_q & aPopReady & ~aFlush;
    ram_nonempty = (wr_ptr_q != rd_ptr_q);
    ram_rd       = ram_nonempty & (~out_valid_q | pop) & ~aFlush;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q | (aPushValid & ~anOutPushReady);

    if (aFlush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (ram_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      out_valid_d = ram_rd | (out_valid_q & ~pop);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (count_d == '0)           state_d = Q_EMPTY;
    else if (count_d == FULL_CNT) state_d = Q_FULL;
    else if (out_valid_d)        state_d = Q_STREAMING;
    else                         state_d = Q_FILLING;
  end

  // State registers; reset wins over every other operation.
  always_ff @(posedge aClock) begin
    if (!aReset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= Q_EMPTY;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  RAM_1R_1W #(.DEPTH(DEPTH), .SIZE(WIDTH)) u_ram (
    .clk     (aClock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (aPushData),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (anOutPopData)
  );

endmodule

// File: tb/tb_primitive_queue.sv
// Bench for primitive_queue: directed stimulus, queue scoreboard checked by a
// negedge monitor, plus directed latency/boundary checks.
module tb_primitive_queue;

  localparam int WIDTH = 96;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 4;

  logic             aClock = 1'b0;
  logic             aReset, aPushValid, aPopReady, aFlush;
  logic [WIDTH-1:0] aPushData;
  logic             anOutPushReady, anOutPopValid, anOutAlmostFull, anOutOverflow;
  logic [WIDTH-1:0] anOutPopData;
  logic [5:0]       anOutCount;

  primitive_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
    .aClock(aClock), .aReset(aReset), .aPushValid(aPushValid), .aPushData(aPushData),
    .anOutPushReady(anOutPushReady), .anOutPopValid(anOutPopValid),
    .anOutPopData(anOutPopData), .aPopReady(aPopReady), .aFlush(aFlush),
    .anOutCount(anOutCount), .anOutAlmostFull(anOutAlmostFull), .anOutOverflow(anOutOverflow)
  );

  always #5 aClock = ~aClock;

  int nchecks = 0;
  int nerrs   = 0;
  int npops   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / reference model, advanced once per cycle at the negedge.
  logic [WIDTH-1:0] exp_q[$];
  int               mcnt = 0;
  logic             mov = 1'b0;
  logic             armed = 1'b0;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data;

  always @(negedge aClock) begin
    logic acc, pp;
    if (armed) begin
      chk("count", 128'(anOutCount), 128'(mcnt));
      chk("push_ready", 128'(anOutPushReady), 128'(mcnt != DEPTH));
      chk("almost_full", 128'(anOutAlmostFull), 128'(mcnt >= AF));
      chk("overflow", 128'(anOutOverflow), 128'(mov));
      chk("spurious_valid", 128'(anOutPopValid && exp_q.size() == 0), 128'(0));
      if (prev_hold) begin
        chk("hold_valid", 128'(anOutPopValid), 128'(1));
        chk("hold_data", 128'(anOutPopData), 128'(prev_data));
      end
    end
    prev_hold = armed && aReset && !aFlush && anOutPopValid && !aPopReady;
    prev_data = anOutPopData;
    if (!aReset) begin
      exp_q.delete();
      mcnt  = 0;
      mov   = 1'b0;
      armed = 1'b1;
      prev_hold = 1'b0;
    end else if (armed) begin
      if (aPushValid && mcnt == DEPTH) mov = 1'b1;
      if (aFlush) begin
        exp_q.delete();
        mcnt = 0;
      end else begin
        acc = aPushValid && (mcnt != DEPTH);
        pp  = anOutPopValid && aPopReady;
        if (pp) begin
          npops++;
          if (exp_q.size() == 0) chk("pop_empty_model", 128'(1), 128'(0));
          else chk("pop_data", 128'(anOutPopData), 128'(exp_q.pop_front()));
        end
        if (acc) exp_q.push_back(aPushData);
        mcnt = mcnt + int'(acc) - int'(pp);
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge aClock);
    #1;
  endtask

  initial begin
    int p0;
    aReset = 1'b0; aPushValid = 1'b0; aPopReady = 1'b0; aFlush = 1'b0; aPushData = '0;
    repeat (3) cyc();
    aReset = 1'b1;
    #2;
    chk("rst_valid", 128'(anOutPopValid), 128'(0));
    chk("rst_count", 128'(anOutCount), 128'(0));
    chk("rst_ready", 128'(anOutPushReady), 128'(1));
    chk("rst_ovf", 128'(anOutOverflow), 128'(0));
    repeat (2) cyc();

    // Single push latency: valid two cycles after the push cycle.
    aPopReady = 1'b1; aPushValid = 1'b1; aPushData = 96'hA1;
    cyc();
    aPushValid = 1'b0;
    #2 chk("lat_n1_valid", 128'(anOutPopValid), 128'(0));
    cyc();
    #2 chk("lat_n2_valid", 128'(anOutPopValid), 128'(1));
    chk("lat_n2_data", 128'(anOutPopData), 128'h0A1);
    cyc();
    #2 chk("lat_n3_count", 128'(anOutCount), 128'(0));
    chk("lat_n3_valid", 128'(anOutPopValid), 128'(0));
    cyc();

    // Fill to full with the consumer stalled.
    aPopReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      aPushValid = 1'b1; aPushData = WIDTH'(i);
      cyc();
      #2 chk("fill_count", 128'(anOutCount), 128'(i + 1));
      chk("fill_af", 128'(anOutAlmostFull), 128'(i + 1 >= AF));
    end
    aPushValid = 1'b0;
    chk("full_ready", 128'(anOutPushReady), 128'(0));
    chk("full_ovf_pre", 128'(anOutOverflow), 128'(0));
    cyc();
    aPushValid = 1'b1; aPushData = 96'h99;
    cyc();
    aPushValid = 1'b0;
    #2 chk("full_ovf", 128'(anOutOverflow), 128'(1));
    chk("full_count_hold", 128'(anOutCount), 128'(DEPTH));

    // Full: simultaneous push and pop, push refused.
    cyc();
    aPopReady = 1'b1; aPushValid = 1'b1; aPushData = 96'h77;
    #2 chk("fullpp_head", 128'(anOutPopData), 128'(0));
    cyc();
    aPushValid = 1'b0; aPopReady = 1'b0;
    #2 chk("fullpp_count", 128'(anOutCount), 128'(DEPTH - 1));
    chk("fullpp_ready", 128'(anOutPushReady), 128'(1));
    aPopReady = 1'b1;
    repeat (40) cyc();
    chk("drain_count", 128'(anOutCount), 128'(0));

    // Continuous streaming with pointer wrap.
    p0 = npops;
    for (int i = 0; i < 100; i++) begin
      aPushValid = 1'b1; aPushData = WIDTH'(32'h100 + i);
      cyc();
    end
    aPushValid = 1'b0;
    #2 chk("stream_rate", 128'(npops - p0), 128'(98));
    repeat (2) cyc();
    chk("stream_total", 128'(npops - p0), 128'(100));
    chk("stream_count", 128'(anOutCount), 128'(0));

    // Flush with 10 entries held and a push in the flush cycle.
    aPopReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      aPushValid = 1'b1; aPushData = WIDTH'(32'h200 + i);
      cyc();
    end
    aPushValid = 1'b1; aPushData = 96'hEE; aFlush = 1'b1;
    cyc();
    aPushValid = 1'b0; aFlush = 1'b0;
    #2 chk("flush_count", 128'(anOutCount), 128'(0));
    chk("flush_valid", 128'(anOutPopValid), 128'(0));
    chk("flush_ovf_kept", 128'(anOutOverflow), 128'(1));
    cyc();
    p0 = npops;
    aPopReady = 1'b1; aPushValid = 1'b1; aPushData = 96'h55;
    cyc();
    aPushValid = 1'b0;
    repeat (4) cyc();
    chk("post_flush_pops", 128'(npops - p0), 128'(1));

    // Reset mid-stream with overflow set.
    for (int i = 0; i < 5; i++) begin
      aPushValid = 1'b1; aPushData = WIDTH'(32'h300 + i);
      cyc();
    end
    aReset = 1'b0;
    cyc();
    aReset = 1'b1; aPushValid = 1'b0;
    #2 chk("mrst_valid", 128'(anOutPopValid), 128'(0));
    chk("mrst_count", 128'(anOutCount), 128'(0));
    chk("mrst_ready", 128'(anOutPushReady), 128'(1));
    chk("mrst_af", 128'(anOutAlmostFull), 128'(0));
    chk("mrst_ovf", 128'(anOutOverflow), 128'(0));
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/primitive_queue.md
PRIMITIVE_QUEUE -- requirements
Module: primitive_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 96, meaning the entry width in bits (one processed primitive).
REQ-002 SHALL have parameter DEPTH, default 32, meaning the total entry capacity; a power of two, at least 4.
REQ-003 SHALL have parameter ALMOST_FULL, default DEPTH-4, meaning the count threshold for anOutAlmostFull; 1..DEPTH.
REQ-004 SHALL have port aClock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aReset, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port aPushValid, input, 1 bit: the producer offers aPushData.
REQ-007 SHALL have port aPushData, input, WIDTH bits: the entry to enqueue.
REQ-008 SHALL have port anOutPushReady, output, 1 bit: the queue accepts an entry this cycle.
REQ-009 SHALL have port anOutPopValid, output, 1 bit: anOutPopData holds the oldest entry.
REQ-010 SHALL have port anOutPopData, output, WIDTH bits: the head entry, driven from a register.
REQ-011 SHALL have port aPopReady, input, 1 bit: the consumer takes the head entry.
REQ-012 SHALL have port aFlush, input, 1 bit: discard all contents (e.g. on frame flip).
REQ-013 SHALL have port anOutCount, output, $clog2(DEPTH)+1 bits: the number of entries held, including the output register.
REQ-014 SHALL have port anOutAlmostFull, output, 1 bit: asserted when anOutCount >= ALMOST_FULL.
REQ-015 SHALL have port anOutOverflow, output, 1 bit: sticky flag set when aPushValid is high while anOutPushReady is low.

Function
REQ-016 SHALL define a push as aPushValid & anOutPushReady, and a pop as anOutPopValid & aPopReady.
REQ-017 SHALL drive anOutPushReady = (anOutCount != DEPTH) from registered state only, with no combinational path from aPopReady.
REQ-018 SHALL be FIFO-ordered: entries pop in push order, none lost or duplicated.
REQ-019 SHALL have latency: a push in cycle N into an empty queue gives anOutPopValid high in cycle N+2, with RAM write at N, read at N+1, and the output register loaded at N+2.
REQ-020 SHALL sustain one push and one pop per cycle in steady state, with a read prefetch issued whenever the output register is empty or being popped and the RAM is non-empty.
REQ-021 SHALL keep anOutPopValid and anOutPopData stable while aPopReady is low.
REQ-022 SHALL, on a simultaneous push and pop, leave anOutCount unchanged; push alone increments it, pop alone decrements it.
REQ-023 SHALL, when full (count == DEPTH), accept a pop; the push in that same cycle is refused and anOutPushReady rises the next cycle.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; pointers carry one extra bit to separate full from empty.
REQ-025 SHALL, on aFlush, zero pointers and count and clear anOutPopValid next cycle; a push or pop in the flush cycle is ignored.
REQ-026 SHALL leave anOutOverflow unaffected by aFlush; only reset clears it.
REQ-027 SHALL use storage state machine states EMPTY (count 0), FILLING (output register empty, RAM read in flight), STREAMING (output valid) and FULL, with transitions driven only by push, pop and flush.

Reset
REQ-028 SHALL, when aReset = 0 at a clock edge, set anOutPopValid=0, anOutCount=0, anOutPushReady=1 (from the next cycle), anOutAlmostFull=0, anOutOverflow=0, pointers=0 and state EMPTY.
REQ-029 SHALL let reset override flush, push and pop in the same cycle; an operation in progress is discarded.
REQ-030 SHALL not reset anOutPopData or RAM contents; their values are don't-care while anOutPopValid=0.

Structure
REQ-031 SHALL place the default WIDTH (the bit width of TriangleData) and the queue state enum in the shared package illusion_pkg.
REQ-032 SHALL instantiate one sub-module, RAM_1R_1W (DEPTH=DEPTH, SIZE=WIDTH), as entry storage with synchronous read; all control logic lives in primitive_queue.

Verification
REQ-033 SHALL verify: push 0xA1 at cycle 5 into an empty queue with aPopReady=1 -> anOutPopValid high at cycle 7 with data 0xA1; count returns to 0.
REQ-034 SHALL verify: push 32 entries 0..31 with aPopReady=0 -> count=32, anOutPushReady=0, anOutAlmostFull high from count 28; a 33rd push sets anOutOverflow=1.
REQ-035 SHALL verify: full queue with push and pop in the same cycle -> pop of 0 succeeds, push refused, count=31, anOutPushReady=1 next cycle.
REQ-036 SHALL verify: continuous push and pop of 100 incrementing entries -> in-order output at 1 entry per cycle after the 2-cycle fill, with pointer wrap exercised 3 times.
REQ-037 SHALL verify: aFlush with 10 entries held plus a simultaneous push -> count=0 and anOutPopValid=0 next cycle; a later push of 0x55 pops as 0x55 only.
REQ-038 SHALL verify: aReset=0 mid-stream with the overflow flag set -> all outputs at REQ-028 values the next cycle.
